// File: rtl/wb_master_if_pkg.sv
// Shared types and constants for the CPU-side Wishbone master adapter.
//  wb_state_e : adapter FSM states (IDLE / BUSY / WAIT_STALL)
//  SEL_W      : Wishbone byte-select width
//  cnt_width  : timeout counter width, never below one bit
package wb_master_if_pkg;

    localparam int unsigned SEL_W = 4;

    typedef enum logic [1:0] {
        WB_IDLE       = 2'b00,
        WB_BUSY       = 2'b01,
        WB_WAIT_STALL = 2'b11
    } wb_state_e;

    // A timeout of 0 disables the counter; keep one bit so the vector stays legal.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/wb_master_if_if.sv
// Wishbone classic bus bundle between a CPU-side master and the interconnect.
//  master : drives addr/wdata/we/sel/stb/cyc, receives rdata/ack
//  slave  : mirror image of master
interface wb_master_if_if
    import wb_master_if_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic              stb;
    logic              cyc;
    logic              ack;

    modport master (
        output addr, wdata, we, sel, stb, cyc,
        input  rdata, ack
    );

    modport slave (
        input  addr, wdata, we, sel, stb, cyc,
        output rdata, ack
    );

endinterface

// File: rtl/wb_master_if.sv
// CPU pipeline memory port to Wishbone classic master adapter.
// Turns a one-cycle CPU request into a single Wishbone cycle, holds the
// pipeline with stallreq_o until ack, parks read data while the consuming
// stage is frozen, aborts on flush and abandons hung cycles with bus_err_o.
// Ports:
//  clk, rst     clock and asynchronous active-low reset
//  stall_i      pipeline stall vector, bit STALL_IDX freezes the consumer
//  flush_i      pipeline flush, aborts any outstanding cycle
//  cpu_*_i      CPU request (valid, write, address, write data, byte lanes)
//  cpu_data_o   read data to the pipeline (combinational)
//  stallreq_o   pipeline hold request (combinational)
//  bus_err_o    one-cycle pulse when a cycle times out (registered)
//  wb           Wishbone master modport (outputs registered)
module wb_master_if
    import wb_master_if_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned STALL_W        = 6,
    parameter int unsigned STALL_IDX      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic               cpu_ce_i,
    input  logic               cpu_we_i,
    input  logic [ADDR_W-1:0]  cpu_addr_i,
    input  logic [DATA_W-1:0]  cpu_data_i,
    input  logic [SEL_W-1:0]   cpu_sel_i,
    output logic [DATA_W-1:0]  cpu_data_o,
    output logic               stallreq_o,
    output logic               bus_err_o,
    wb_master_if_if.master     wb
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    wb_state_e         state;
    wb_state_e         state_next;
    logic [DATA_W-1:0] rd_buf;
    logic [CNT_W-1:0]  cnt;
    logic              timeout_hit;
    logic              consumer_stalled;
    logic              req_start;
    logic              unused_stall;

    assign consumer_stalled = stall_i[STALL_IDX];
    assign unused_stall     = ^stall_i;
    assign req_start        = cpu_ce_i && !flush_i;

    // Last BUSY cycle before the hung cycle is abandoned; never true when disabled.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush beats ack, ack beats timeout
    always_comb begin
        state_next = state;
        case (state)
            WB_IDLE: begin
                if (req_start) begin
                    state_next = WB_BUSY;
                end
            end
            WB_BUSY: begin
                if (flush_i) begin
                    state_next = WB_IDLE;
                end else if (wb.ack) begin
                    state_next = consumer_stalled ? WB_WAIT_STALL : WB_IDLE;
                end else if (timeout_hit) begin
                    state_next = WB_IDLE;
                end
            end
            WB_WAIT_STALL: begin
                if (flush_i || !consumer_stalled) begin
                    state_next = WB_IDLE;
                end
            end
            default: state_next = WB_IDLE;
        endcase
    end

    // Pipeline-facing combinational outputs, forced low while in reset
    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        if (rst) begin
            case (state)
                WB_IDLE: begin
                    stallreq_o = req_start;
                end
                WB_BUSY: begin
                    if (!flush_i) begin
                        if (wb.ack) begin
                            if (!wb.we) begin
                                cpu_data_o = wb.rdata;
                            end
                        end else if (!timeout_hit) begin
                            stallreq_o = 1'b1;
                        end
                    end
                end
                WB_WAIT_STALL: begin
                    cpu_data_o = rd_buf;
                end
                default: ;
            endcase
        end
    end

    // Wishbone registers, read buffer, timeout counter and error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb.addr   <= '0;
            wb.wdata  <= '0;
            wb.we     <= 1'b0;
            wb.sel    <= '0;
            wb.stb    <= 1'b0;
            wb.cyc    <= 1'b0;
            rd_buf    <= '0;
            cnt       <= '0;
            bus_err_o <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                WB_IDLE: begin
                    if (req_start) begin
                        wb.addr  <= cpu_addr_i;
                        wb.wdata <= cpu_data_i;
                        wb.we    <= cpu_we_i;
                        wb.sel   <= cpu_sel_i;
                        wb.stb   <= 1'b1;
                        wb.cyc   <= 1'b1;
                        cnt      <= '0;
                    end
                end
                WB_BUSY: begin
                    if (flush_i) begin
                        wb.stb <= 1'b0;
                        wb.cyc <= 1'b0;
                    end else if (wb.ack) begin
                        wb.stb <= 1'b0;
                        wb.cyc <= 1'b0;
                        if (!wb.we) begin
                            rd_buf <= wb.rdata;
                        end
                    end else if (timeout_hit) begin
                        wb.stb    <= 1'b0;
                        wb.cyc    <= 1'b0;
                        bus_err_o <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
            // A flush discards parked data from any state.
            if (flush_i) begin
                rd_buf <= '0;
            end
        end
    end

endmodule
